rv32_memory_responder: RTL and testbench

Memory-side responder for the RV32 core's instruction and data buses: it answers instruction fetches and data loads/stores from on-chip instruction and data RAMs, decoding by address region. It adds a boot-load port that fills memory word by word while the core is held in reset, then releases the core. It sits beside the core top and is wired to the core's instruction address, data address, byte write-enable and write-data outputs, and to its instruction and read-data inputs.

---
 rtl/rv32_memory_responder.sv | 149 ++++++++++++++
 tb/tb_rv32_memory_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32_memory_responder.sv
// Instruction/data RAM responder for the RV32 core, with a boot-load port that
// fills memory while holding the core in reset.
module rv32_memory_responder #(
  parameter int unsigned IMEM_WORDS = 32768,
  parameter int unsigned DMEM_WORDS = 32768,
  parameter bit          BOOT_EN    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_o,
  input  logic [31:0] data_addr_i,
  input  logic [3:0]  data_we_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  input  logic        load_valid_i,
  output logic        load_ready_o,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  input  logic        load_last_i,
  output logic        core_rst_o,
  output logic        fault_o,
  output logic [31:0] fault_addr_o
);

  localparam int unsigned IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int unsigned DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  typedef enum logic {ST_BOOT, ST_RUN} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_IMEM, SEL_DMEM} sel_t;

  localparam state_t RESET_STATE = BOOT_EN ? ST_BOOT : ST_RUN;

  function automatic logic in_imem(input logic [31:0] a);
    return (a[31:28] == 4'h0) && ({6'd0, a[27:2]} < 32'(IMEM_WORDS));
  endfunction

  function automatic logic in_dmem(input logic [31:0] a);
    return (a[31:28] == 4'h1) && ({6'd0, a[27:2]} < 32'(DMEM_WORDS));
  endfunction

  function automatic logic is_fault(input logic [31:0] a);
    return ((a[31:28] == 4'h0) && !in_imem(a)) || ((a[31:28] == 4'h1) && !in_dmem(a));
  endfunction

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  state_t      state_q, state_d;
  sel_t        rsel_q, rsel_d;
  logic        fetch_hit_q, fetch_hit;
  logic [31:0] imem_a_q, imem_b_q, dmem_q;
  logic        fault_q;
  logic [31:0] fault_addr_q;

  logic        boot_acc, run_act, b_active, imem_b_hit, dmem_hit, fault_now;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_we;
  logic [IAW-1:0] a_idx, b_iidx;
  logic [DAW-1:0] b_didx;
  logic        unused_ok;

  // Shared port B: the loader owns it in BOOT, the core's data port in RUN.
  // Gating with rst_i drops any write in a reset cycle.
  always_comb begin
    boot_acc   = (state_q == ST_BOOT) && load_valid_i && !rst_i;
    run_act    = (state_q == ST_RUN) && !rst_i;
    b_active   = boot_acc || run_act;
    b_addr     = (state_q == ST_BOOT) ? load_addr_i : data_addr_i;
    b_wdata    = (state_q == ST_BOOT) ? load_data_i : data_wdata_i;
    b_we       = boot_acc ? '1 : (run_act ? data_we_i : '0);
    imem_b_hit = in_imem(b_addr);
    dmem_hit   = in_dmem(b_addr);
    fault_now  = b_active && is_fault(b_addr);
    fetch_hit  = !rst_i && in_imem(instr_addr_i);
    a_idx      = instr_addr_i[IAW+1:2];
    b_iidx     = b_addr[IAW+1:2];
    b_didx     = b_addr[DAW+1:2];
    rsel_d     = SEL_NONE;
    if (run_act) begin
      if (imem_b_hit)    rsel_d = SEL_IMEM;
      else if (dmem_hit) rsel_d = SEL_DMEM;
    end
  end

  assign unused_ok = ^instr_addr_i[1:0];

  always_ff @(posedge clk_i) begin
    imem_a_q <= imem[a_idx];
    imem_b_q <= imem[b_iidx];
    for (int unsigned n = 0; n < 4; n++) begin
      if (b_we[n] && imem_b_hit) imem[b_iidx][8*n +: 8] <= b_wdata[8*n +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    dmem_q <= dmem[b_didx];
    for (int unsigned n = 0; n < 4; n++) begin
      if (b_we[n] && dmem_hit) dmem[b_didx][8*n +: 8] <= b_wdata[8*n +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RESET_STATE;
      rsel_q       <= SEL_NONE;
      fetch_hit_q  <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      rsel_q      <= rsel_d;
      fetch_hit_q <= fetch_hit;
      if (fault_now && !fault_q) begin
        fault_q      <= 1'b1;
        fault_addr_q <= b_addr;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: if (boot_acc && load_last_i) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = RESET_STATE;
    endcase
  end

  // Handshake outputs follow rst_i directly so the reset cycle shows the
  // reset values while the first cycle after it already reflects the state.
  always_comb begin
    load_ready_o = (state_q == ST_BOOT) && !rst_i;
    core_rst_o   = rst_i || (state_q != ST_RUN);
  end

  always_comb begin
    instr_o = fetch_hit_q ? imem_a_q : '0;
    case (rsel_q)
      SEL_IMEM: data_rdata_o = imem_b_q;
      SEL_DMEM: data_rdata_o = dmem_q;
      default:  data_rdata_o = '0;
    endcase
  end

  assign fault_o      = fault_q;
  assign fault_addr_o = fault_addr_q;

endmodule

// File: tb/tb_rv32_memory_responder.sv
// Randomized bench for rv32_memory_responder against a word-level memory model.
module tb_rv32_memory_responder;
  localparam int unsigned IW = 32768;
  localparam int unsigned DW = 32768;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] instr_addr_i, instr_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]  data_we_i;
  logic        load_valid_i, load_ready_o, load_last_i;
  logic [31:0] load_addr_i, load_data_i;
  logic        core_rst_o, fault_o;
  logic [31:0] fault_addr_o;

  always #5 clk = ~clk;

  rv32_memory_responder #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .BOOT_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_addr_i(instr_addr_i), .instr_o(instr_o),
    .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_wdata_i(data_wdata_i),
    .data_rdata_o(data_rdata_o),
    .load_valid_i(load_valid_i), .load_ready_o(load_ready_o), .load_addr_i(load_addr_i),
    .load_data_i(load_data_i), .load_last_i(load_last_i),
    .core_rst_o(core_rst_o), .fault_o(fault_o), .fault_addr_o(fault_addr_o)
  );

  int checks = 0;
  int errors = 0;
  bit [31:0] imem_m [int unsigned];
  bit [31:0] dmem_m [int unsigned];
  bit        fault_m = 1'b0;
  bit [31:0] faddr_m = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] mem_read(input bit [31:0] a);
    int unsigned off = 32'(a[27:2]);
    if (a[31:28] == 4'h0 && off < IW) return imem_m.exists(off) ? imem_m[off] : 32'h0;
    if (a[31:28] == 4'h1 && off < DW) return dmem_m.exists(off) ? dmem_m[off] : 32'h0;
    return 32'h0;
  endfunction

  function automatic bit [31:0] fetch_exp(input bit [31:0] a);
    return (a[31:28] == 4'h0) ? mem_read(a) : 32'h0;
  endfunction

  function automatic bit is_fault_m(input bit [31:0] a);
    int unsigned off = 32'(a[27:2]);
    return (a[31:28] == 4'h0 && off >= IW) || (a[31:28] == 4'h1 && off >= DW);
  endfunction

  function automatic void mem_write(input bit [31:0] a, input bit [3:0] we, input bit [31:0] d);
    int unsigned off = 32'(a[27:2]);
    bit [31:0] w = mem_read(a);
    for (int n = 0; n < 4; n++) if (we[n]) w[8*n +: 8] = d[8*n +: 8];
    if (a[31:28] == 4'h0 && off < IW) imem_m[off] = w;
    else if (a[31:28] == 4'h1 && off < DW) dmem_m[off] = w;
  endfunction

  // 16 IMEM words at 0x0 and 16 DMEM words at 0x1000_0000.
  function automatic bit [31:0] pool_addr(input int unsigned k);
    return (k < 16) ? 32'(k) * 4 : 32'h1000_0000 + 32'(k - 16) * 4;
  endfunction

  task automatic load_word(input bit [31:0] a, input bit [31:0] d, input bit last);
    repeat ($urandom_range(0, 2)) begin
      load_valid_i = 1'b0;
      @(posedge clk); #1;
    end
    check_eq("boot_ready", 32'(load_ready_o), 32'd1);
    check_eq("boot_core_rst", 32'(core_rst_o), 32'd1);
    load_valid_i = 1'b1; load_addr_i = a; load_data_i = d; load_last_i = last;
    @(posedge clk); #1;
    load_valid_i = 1'b0; load_last_i = 1'b0;
    mem_write(a, 4'hF, d);
  endtask

  task automatic run_op(input bit [31:0] ia, input bit [31:0] da, input bit [3:0] we,
                        input bit [31:0] wd);
    bit [31:0] ei, ed;
    ei = fetch_exp(ia);
    ed = mem_read(da);
    if (is_fault_m(da) && !fault_m) begin
      fault_m = 1'b1;
      faddr_m = da;
    end
    instr_addr_i = ia; data_addr_i = da; data_we_i = we; data_wdata_i = wd;
    load_valid_i = 1'($urandom_range(0, 1)); load_addr_i = da; load_data_i = ~wd;
    @(posedge clk); #1;
    data_we_i = '0; load_valid_i = 1'b0;
    mem_write(da, we, wd);
    check_eq("instr", instr_o, ei);
    check_eq("rdata", data_rdata_o, ed);
    check_eq("fault", 32'(fault_o), 32'(fault_m));
    check_eq("fault_addr", fault_addr_o, faddr_m);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned order [$];
    bit [31:0] old_w;

    rst_i = 1'b1; instr_addr_i = '0; data_addr_i = '0; data_we_i = '0; data_wdata_i = '0;
    load_valid_i = 1'b0; load_addr_i = '0; load_data_i = '0; load_last_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_rdata", data_rdata_o, 32'h0);
    check_eq("rst_ready", 32'(load_ready_o), 32'd0);
    check_eq("rst_core_rst", 32'(core_rst_o), 32'd1);
    check_eq("rst_fault", 32'(fault_o), 32'd0);
    check_eq("rst_fault_addr", fault_addr_o, 32'h0);
    rst_i = 1'b0; #1;
    check_eq("post_rst_ready", 32'(load_ready_o), 32'd1);

    // Two words, then reset with a loader word presented in the reset cycle.
    load_word(pool_addr(20), $urandom, 1'b0);
    load_word(pool_addr(3), $urandom, 1'b0);
    rst_i = 1'b1; load_valid_i = 1'b1; load_addr_i = pool_addr(20);
    load_data_i = 32'hBAD0_BAD0; load_last_i = 1'b1;
    @(posedge clk); #1;
    load_valid_i = 1'b0; load_last_i = 1'b0;
    check_eq("midrst_ready", 32'(load_ready_o), 32'd0);
    check_eq("midrst_core_rst", 32'(core_rst_o), 32'd1);
    check_eq("midrst_fault", 32'(fault_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0; #1;
    check_eq("midrst_ready_after", 32'(load_ready_o), 32'd1);
    check_eq("midrst_core_rst_after", 32'(core_rst_o), 32'd1);

    for (int unsigned k = 0; k < 32; k++) if (k != 20) order.push_back(k);
    order.shuffle();
    foreach (order[i]) load_word(pool_addr(order[i]), $urandom, 1'b0);
    load_word(32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
    load_word(32'h1000_0004, 32'h1234_5678, 1'b1);
    check_eq("boot_done_core_rst", 32'(core_rst_o), 32'd0);
    check_eq("boot_done_ready", 32'(load_ready_o), 32'd0);

    run_op(32'h0, 32'h1000_0004, 4'h0, 32'h0);
    check_eq("boot_fetch", instr_o, 32'hDEAD_BEEF);
    check_eq("boot_load", data_rdata_o, 32'h1234_5678);

    run_op(32'h0, pool_addr(20), 4'h0, 32'h0);

    run_op(32'h4, 32'h1000_0000, 4'hF, 32'h1122_3344);
    run_op(32'h4, 32'h1000_0000, 4'b0010, 32'h0000_AA00);
    run_op(32'h4, 32'h1000_0000, 4'h0, 32'h0);
    check_eq("byte_lane", data_rdata_o, 32'h1122_AA44);

    run_op(32'h8, 32'h1000_0008, 4'hF, 32'h0);
    run_op(32'h8, 32'h1000_0008, 4'hF, 32'hCAFE_F00D);
    check_eq("read_first_old", data_rdata_o, 32'h0);
    run_op(32'h8, 32'h1000_0008, 4'h0, 32'h0);
    check_eq("read_first_new", data_rdata_o, 32'hCAFE_F00D);

    old_w = mem_read(32'h10);
    run_op(32'h10, 32'h10, 4'hF, 32'h55AA_1234);
    check_eq("conc_fetch_old", instr_o, old_w);
    run_op(32'h10, 32'h0, 4'h0, 32'h0);
    check_eq("conc_fetch_new", instr_o, 32'h55AA_1234);

    run_op(32'h0, 32'h2000_0000, 4'hF, 32'h7777_7777);
    check_eq("unmapped_no_fault", 32'(fault_o), 32'd0);
    run_op(32'h0, 32'h2000_0000, 4'h0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      bit [31:0] ia, da;
      bit [3:0]  we;
      ia = ($urandom_range(0, 7) == 0) ? pool_addr($urandom_range(16, 31))
                                       : pool_addr($urandom_range(0, 15));
      ia = ia | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) da = {4'($urandom_range(2, 15)), 28'($urandom)};
      else da = pool_addr($urandom_range(0, 31)) | 32'($urandom_range(0, 3));
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      run_op(ia, da, we, $urandom);
    end

    run_op(32'h0, 32'h1002_0000, 4'h0, 32'h0);
    check_eq("range_rdata", data_rdata_o, 32'h0);
    check_eq("range_fault", 32'(fault_o), 32'd1);
    check_eq("range_fault_addr", fault_addr_o, 32'h1002_0000);
    run_op(32'h0, 32'h0002_0000, 4'hF, 32'h0BAD_F00D);
    check_eq("range_sticky_addr", fault_addr_o, 32'h1002_0000);
    run_op(32'h0, 32'h1000_0000, 4'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
